uart_rx_param: RTL and testbench

Parametrised, oversampling UART receiver for the FPGA serial path. It sits directly behind the RxD pin, and is configurable in data width, oversampling ratio, parity mode and stop-bit count. It recovers each frame with a 3-sample majority vote at mid-bit and rejects glitched start bits. Each received word is presented on a valid/ready output with per-word framing, parity and overrun status.

---
 rtl/uart_rx_param.sv | 201 ++++++++++++++++++++
 tb/tb_uart_rx_param.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_param.sv
// Oversampling UART receiver: 2-FF synchroniser, tick divider, 3-sample
// mid-bit majority vote, optional parity, 1 or 2 stop bits, and a
// valid/ready output holding one word with frame/parity/overrun status.
module uart_rx_param #(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUD_RATE  = 9_600,
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                 clk_fpga,
  input  logic                 reset,
  input  logic                 rxd,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam int DIV   = CLK_FREQ / (BAUD_RATE * OVERSAMPLE);
  localparam int DIV_W = $clog2(DIV);
  localparam int SC_W  = $clog2(OVERSAMPLE);
  localparam int BI_W  = $clog2(DATA_BITS + 1);
  localparam int M     = OVERSAMPLE / 2;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
  localparam logic [SC_W-1:0]  SC_M_LO  = SC_W'(M - 1);
  localparam logic [SC_W-1:0]  SC_M     = SC_W'(M);
  localparam logic [SC_W-1:0]  SC_M_HI  = SC_W'(M + 1);
  localparam logic [SC_W-1:0]  SC_LAST  = SC_W'(OVERSAMPLE - 1);
  localparam logic [BI_W-1:0]  BI_LAST  = BI_W'(DATA_BITS - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_PAR   = 3'd3;
  localparam logic [2:0] S_STOP  = 3'd4;

  logic                 rxd_m, rxd_s;
  logic [DIV_W-1:0]     div_cnt;
  logic                 tick;
  logic [2:0]           state;
  logic [SC_W-1:0]      sc;
  logic [BI_W-1:0]      bit_idx;
  logic                 stop_idx;
  logic                 stop_last;
  logic [DATA_BITS-1:0] shreg;
  logic                 perr_acc, ferr_acc;
  logic [1:0]           samp;
  logic                 vote;
  logic                 par_x;
  logic                 complete;

  assign tick      = (div_cnt == DIV_LAST);
  assign vote      = (samp[0] & samp[1]) | (samp[0] & rxd_s) | (samp[1] & rxd_s);
  assign par_x     = (^shreg) ^ vote;
  assign stop_last = (STOP_BITS == 1) || stop_idx;
  assign complete  = tick && (state == S_STOP) && (sc == SC_M_HI) && stop_last;
  assign busy      = (state != S_IDLE);

  // Two-flop synchroniser; resets to the idle line level.
  always_ff @(posedge clk_fpga) begin
    if (reset) begin
      rxd_m <= 1'b1;
      rxd_s <= 1'b1;
    end else begin
      rxd_m <= rxd;
      rxd_s <= rxd_m;
    end
  end

  // Free-running oversample tick divider.
  always_ff @(posedge clk_fpga) begin
    if (reset)     div_cnt <= '0;
    else if (tick) div_cnt <= '0;
    else           div_cnt <= div_cnt + 1'b1;
  end

  // Capture the two early vote samples; the third is the live synced bit at M+1.
  always_ff @(posedge clk_fpga) begin
    if (reset) begin
      samp <= 2'b11;
    end else if (tick) begin
      if (sc == SC_M_LO) samp[0] <= rxd_s;
      if (sc == SC_M)    samp[1] <= rxd_s;
    end
  end

  // Frame FSM: sample counter and bit index only move under explicit control.
  always_ff @(posedge clk_fpga) begin
    if (reset) begin
      state    <= S_IDLE;
      sc       <= '0;
      bit_idx  <= '0;
      stop_idx <= 1'b0;
      shreg    <= '0;
      perr_acc <= 1'b0;
      ferr_acc <= 1'b0;
    end else if (tick) begin
      case (state)
        S_IDLE: begin
          if (!rxd_s) begin
            state    <= S_START;
            sc       <= '0;
            bit_idx  <= '0;
            stop_idx <= 1'b0;
            perr_acc <= 1'b0;
            ferr_acc <= 1'b0;
          end
        end
        S_START: begin
          if (sc == SC_M_HI && vote) begin
            // glitch shorter than half a bit: not a real start
            state <= S_IDLE;
            sc    <= '0;
          end else if (sc == SC_LAST) begin
            state   <= S_DATA;
            sc      <= '0;
            bit_idx <= '0;
          end else begin
            sc <= sc + 1'b1;
          end
        end
        S_DATA: begin
          if (sc == SC_M_HI) shreg <= {vote, shreg[DATA_BITS-1:1]};
          if (sc == SC_LAST) begin
            sc <= '0;
            if (bit_idx == BI_LAST) begin
              bit_idx <= '0;
              state   <= (PARITY != 0) ? S_PAR : S_STOP;
            end else begin
              bit_idx <= bit_idx + 1'b1;
            end
          end else begin
            sc <= sc + 1'b1;
          end
        end
        S_PAR: begin
          if (sc == SC_M_HI) perr_acc <= (PARITY == 1) ? ~par_x : par_x;
          if (sc == SC_LAST) begin
            sc       <= '0;
            stop_idx <= 1'b0;
            state    <= S_STOP;
          end else begin
            sc <= sc + 1'b1;
          end
        end
        S_STOP: begin
          if (sc == SC_M_HI) begin
            if (!vote) ferr_acc <= 1'b1;
            if (stop_last) begin
              // finish mid stop bit so a following start edge is not missed
              state <= S_IDLE;
              sc    <= '0;
            end else begin
              sc <= sc + 1'b1;
            end
          end else if (sc == SC_LAST) begin
            sc       <= '0;
            stop_idx <= 1'b1;
          end else begin
            sc <= sc + 1'b1;
          end
        end
        default: begin
          state <= S_IDLE;
          sc    <= '0;
        end
      endcase
    end
  end

  // Output word register: load on completion if free, else flag overrun.
  always_ff @(posedge clk_fpga) begin
    if (reset) begin
      rx_valid   <= 1'b0;
      rx_data    <= '0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
      overrun    <= 1'b0;
    end else if (complete) begin
      if (!rx_valid || rx_ready) begin
        rx_data    <= shreg;
        frame_err  <= ferr_acc | ~vote;
        parity_err <= (PARITY != 0) && perr_acc;
        overrun    <= 1'b0;
        rx_valid   <= 1'b1;
      end else begin
        overrun <= 1'b1;
      end
    end else if (rx_valid && rx_ready) begin
      rx_valid <= 1'b0;
      overrun  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_rx_param.sv
// Bench for uart_rx_param: three instances (8N1, 7E1, 8N2) driven by a
// bit-level frame generator; delivered words are logged and compared with
// expectations computed from frame contents.
module tb_uart_rx_param;

  localparam int BIT = 160;

  logic clk_fpga = 1'b0;
  logic reset;
  logic [2:0] rxd_l, rdy;
  logic [7:0] d0, d2;
  logic [6:0] d1;
  logic [2:0] v, fe, pe, ov, bz;

  always #5 clk_fpga = ~clk_fpga;

  uart_rx_param #(.CLK_FREQ(1_600_000), .BAUD_RATE(10_000), .OVERSAMPLE(16),
                  .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) dut0 (
    .clk_fpga(clk_fpga), .reset(reset), .rxd(rxd_l[0]), .rx_data(d0),
    .rx_valid(v[0]), .rx_ready(rdy[0]), .frame_err(fe[0]),
    .parity_err(pe[0]), .overrun(ov[0]), .busy(bz[0]));

  uart_rx_param #(.CLK_FREQ(1_600_000), .BAUD_RATE(10_000), .OVERSAMPLE(16),
                  .DATA_BITS(7), .PARITY(2), .STOP_BITS(1)) dut1 (
    .clk_fpga(clk_fpga), .reset(reset), .rxd(rxd_l[1]), .rx_data(d1),
    .rx_valid(v[1]), .rx_ready(rdy[1]), .frame_err(fe[1]),
    .parity_err(pe[1]), .overrun(ov[1]), .busy(bz[1]));

  uart_rx_param #(.CLK_FREQ(1_600_000), .BAUD_RATE(10_000), .OVERSAMPLE(16),
                  .DATA_BITS(8), .PARITY(0), .STOP_BITS(2)) dut2 (
    .clk_fpga(clk_fpga), .reset(reset), .rxd(rxd_l[2]), .rx_data(d2),
    .rx_valid(v[2]), .rx_ready(rdy[2]), .frame_err(fe[2]),
    .parity_err(pe[2]), .overrun(ov[2]), .busy(bz[2]));

  typedef struct packed {
    logic [8:0] d;
    logic       fe;
    logic       pe;
    logic       ov;
  } word_t;

  word_t q0[$], q1[$], q2[$];
  int vcyc0 = 0;
  int checks = 0;
  int errors = 0;

  // Log every accepted word (valid & ready) per instance.
  always @(negedge clk_fpga) begin
    if (!reset) begin
      if (v[0]) vcyc0 <= vcyc0 + 1;
      if (v[0] && rdy[0]) q0.push_back({1'b0, d0, fe[0], pe[0], ov[0]});
      if (v[1] && rdy[1]) q1.push_back({2'b0, d1, fe[1], pe[1], ov[1]});
      if (v[2] && rdy[2]) q2.push_back({1'b0, d2, fe[2], pe[2], ov[2]});
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk_fpga);
    #1;
  endtask

  task automatic send_bits(input int u, input logic [15:0] b, input int n);
    for (int i = 0; i < n; i++) begin
      rxd_l[u] = b[i];
      cyc(BIT);
    end
    rxd_l[u] = 1'b1;
  endtask

  // start, nb data bits LSB first, optional parity bit, nstop stop bits
  task automatic send_frame(input int u, input logic [8:0] data, input int nb,
                            input bit has_par, input logic pbit,
                            input logic [1:0] stops, input int nstop);
    logic [15:0] b;
    int n;
    b = '1;
    b[0] = 1'b0;
    n = 1;
    for (int i = 0; i < nb; i++) begin b[n] = data[i]; n++; end
    if (has_par) begin b[n] = pbit; n++; end
    for (int i = 0; i < nstop; i++) begin b[n] = stops[i]; n++; end
    send_bits(u, b, n);
  endtask

  task automatic test_reset;
    reset = 1'b1; rxd_l = 3'b111; rdy = 3'b111;
    cyc(4);
    checks++; if (v !== 3'b000) begin errors++; $display("FAIL reset_valid: got %b exp 000", v); end
    checks++; if (bz !== 3'b000) begin errors++; $display("FAIL reset_busy: got %b exp 000", bz); end
    checks++; if ({fe, pe, ov} !== 9'd0) begin errors++; $display("FAIL reset_flags: got %b exp 0", {fe, pe, ov}); end
    checks++; if ({d0, d1, d2} !== 23'd0) begin errors++; $display("FAIL reset_data: got %h exp 0", {d0, d1, d2}); end
    reset = 1'b0;
    cyc(20);
  endtask

  task automatic test_8n1;
    word_t w;
    int base;
    base = vcyc0;
    send_frame(0, 9'h0A5, 8, 1'b0, 1'b0, 2'b11, 1);
    cyc(200);
    checks++;
    if (q0.size() != 1) begin
      errors++; $display("FAIL 8n1_count: got %0d exp 1", q0.size());
    end else begin
      w = q0.pop_front();
      checks++; if (w.d !== 9'h0A5) begin errors++; $display("FAIL 8n1_data: got %h exp a5", w.d); end
      checks++; if ({w.fe, w.pe, w.ov} !== 3'b000) begin errors++; $display("FAIL 8n1_flags: got %b exp 000", {w.fe, w.pe, w.ov}); end
    end
    checks++; if (vcyc0 - base != 1) begin errors++; $display("FAIL 8n1_pulse: got %0d exp 1", vcyc0 - base); end
    q0.delete();
  endtask

  task automatic test_random_8n1;
    word_t e[$];
    word_t w;
    logic [7:0] dat;
    for (int k = 0; k < 10; k++) begin
      dat = 8'($urandom);
      send_frame(0, {1'b0, dat}, 8, 1'b0, 1'b0, 2'b11, 1);
      e.push_back({1'b0, dat, 3'b000});
      cyc($urandom_range(1, 300));
    end
    cyc(200);
    checks++; if (q0.size() != e.size()) begin errors++; $display("FAIL rand_count: got %0d exp %0d", q0.size(), e.size()); end
    while (q0.size() > 0 && e.size() > 0) begin
      w = q0.pop_front();
      checks++;
      if (w !== e[0]) begin errors++; $display("FAIL rand_word: got %h exp %h", w, e[0]); end
      void'(e.pop_front());
    end
    q0.delete();
  endtask

  task automatic test_parity;
    word_t e[$];
    word_t w;
    logic [6:0] dat;
    logic pb;
    for (int k = 0; k < 8; k++) begin
      if (k < 2) begin dat = 7'h53; pb = (k == 1); end
      else begin dat = 7'($urandom); pb = 1'($urandom); end
      send_frame(1, {2'b0, dat}, 7, 1'b1, pb, 2'b11, 1);
      // even parity: total count of ones over data+parity must be even
      e.push_back({2'b0, dat, 1'b0, (pb != (^dat)), 1'b0});
      cyc(BIT);
    end
    cyc(200);
    checks++; if (q1.size() != e.size()) begin errors++; $display("FAIL par_count: got %0d exp %0d", q1.size(), e.size()); end
    while (q1.size() > 0 && e.size() > 0) begin
      w = q1.pop_front();
      checks++;
      if (w !== e[0]) begin errors++; $display("FAIL par_word: got %h exp %h", w, e[0]); end
      void'(e.pop_front());
    end
    q1.delete();
  endtask

  task automatic test_stop2;
    word_t w;
    logic [7:0] dat;
    dat = 8'($urandom);
    send_frame(2, {1'b0, dat}, 8, 1'b0, 1'b0, 2'b01, 2);
    cyc(3 * BIT);
    send_frame(2, 9'h03C, 8, 1'b0, 1'b0, 2'b11, 2);
    cyc(200);
    checks++;
    if (q2.size() != 2) begin
      errors++; $display("FAIL stop2_count: got %0d exp 2", q2.size());
    end else begin
      w = q2.pop_front();
      checks++; if (w !== {1'b0, dat, 3'b100}) begin errors++; $display("FAIL stop2_ferr: got %h exp %h", w, {1'b0, dat, 3'b100}); end
      w = q2.pop_front();
      checks++; if (w !== {9'h03C, 3'b000}) begin errors++; $display("FAIL stop2_clean: got %h exp %h", w, {9'h03C, 3'b000}); end
    end
    q2.delete();
  endtask

  task automatic test_false_start;
    int base;
    base = vcyc0;
    rxd_l[0] = 1'b0;
    cyc(30);
    checks++; if (bz[0] !== 1'b1) begin errors++; $display("FAIL glitch_busy_hi: got %b exp 1", bz[0]); end
    cyc(10);
    rxd_l[0] = 1'b1;
    cyc(BIT - 40);
    checks++; if (bz[0] !== 1'b0) begin errors++; $display("FAIL glitch_busy_lo: got %b exp 0", bz[0]); end
    cyc(2 * BIT);
    checks++; if (vcyc0 != base) begin errors++; $display("FAIL glitch_valid: got %0d exp %0d", vcyc0, base); end
  endtask

  task automatic test_overrun;
    word_t w;
    rdy[0] = 1'b0;
    send_frame(0, 9'h011, 8, 1'b0, 1'b0, 2'b11, 1);
    send_frame(0, 9'h022, 8, 1'b0, 1'b0, 2'b11, 1);
    send_frame(0, 9'h033, 8, 1'b0, 1'b0, 2'b11, 1);
    cyc(100);
    checks++; if (v[0] !== 1'b1) begin errors++; $display("FAIL ovr_valid: got %b exp 1", v[0]); end
    checks++; if (d0 !== 8'h11) begin errors++; $display("FAIL ovr_data: got %h exp 11", d0); end
    checks++; if (ov[0] !== 1'b1) begin errors++; $display("FAIL ovr_flag: got %b exp 1", ov[0]); end
    rdy[0] = 1'b1;
    cyc(1);
    rdy[0] = 1'b0;
    checks++; if (v[0] !== 1'b0) begin errors++; $display("FAIL ovr_drop: got %b exp 0", v[0]); end
    checks++; if (ov[0] !== 1'b0) begin errors++; $display("FAIL ovr_clear: got %b exp 0", ov[0]); end
    checks++;
    if (q0.size() != 1) begin
      errors++; $display("FAIL ovr_count: got %0d exp 1", q0.size());
    end else begin
      w = q0.pop_front();
      checks++; if (w !== {9'h011, 3'b001}) begin errors++; $display("FAIL ovr_word: got %h exp %h", w, {9'h011, 3'b001}); end
    end
    q0.delete();
    rdy[0] = 1'b1;
    cyc(BIT);
  endtask

  task automatic test_reset_mid;
    word_t w;
    logic [7:0] dat;
    dat = 8'h7E;
    rxd_l[0] = 1'b0;
    cyc(BIT);
    for (int i = 0; i < 4; i++) begin rxd_l[0] = dat[i]; cyc(BIT); end
    rxd_l[0] = dat[4];
    cyc(80);
    checks++; if (bz[0] !== 1'b1) begin errors++; $display("FAIL rst_mid_busy: got %b exp 1", bz[0]); end
    reset = 1'b1;
    cyc(2);
    checks++; if ({v[0], bz[0], fe[0], pe[0], ov[0], d0} !== 13'd0) begin
      errors++; $display("FAIL rst_mid_outs: got %h exp 0", {v[0], bz[0], fe[0], pe[0], ov[0], d0}); end
    reset = 1'b0;
    rxd_l[0] = 1'b1;
    cyc(2 * BIT);
    send_frame(0, 9'h081, 8, 1'b0, 1'b0, 2'b11, 1);
    cyc(200);
    checks++;
    if (q0.size() != 1) begin
      errors++; $display("FAIL rst_next_count: got %0d exp 1", q0.size());
    end else begin
      w = q0.pop_front();
      checks++; if (w !== {9'h081, 3'b000}) begin errors++; $display("FAIL rst_next_word: got %h exp %h", w, {9'h081, 3'b000}); end
    end
    q0.delete();
  endtask

  initial begin
    test_reset;
    test_8n1;
    test_random_8n1;
    test_parity;
    test_stop2;
    test_false_start;
    test_overrun;
    test_reset_mid;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
